// File: rtl/execute_multdiv.sv
// execute_multdiv
//   Iterative signed multiply / divide unit for the execute stage. A start
//   request (ctrl_MULT or ctrl_DIV) in IDLE captures the forwarded operands.
//   The unit then runs WIDTH iteration cycles and presents the result with a
//   one-cycle ready pulse. The upstream stages are stalled while it works.
//
// Ports
//   clock           : single clock, rising edge
//   reset_n         : asynchronous active-low reset
//   ctrl_MULT       : start signed multiply (IDLE only; wins over ctrl_DIV)
//   ctrl_DIV        : start signed divide (IDLE only)
//   data_operandA   : multiplicand / dividend
//   data_operandB   : multiplier / divisor
//   data_result     : low WIDTH bits of the product, or the quotient (held)
//   data_exception  : multiply overflow, divide by zero or divide overflow (held)
//   data_resultRDY  : one-cycle result-valid pulse
//   stall           : hold upstream pipeline registers
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a start request; operands are latched on a start
// S_RUN   | one Booth / restoring-division iteration per clock, WIDTH total
// S_DONE  | result registers valid, data_resultRDY high for this cycle

module execute_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    // Multiply: multiplicand. Divide: divisor magnitude.
    logic [WIDTH-1:0] opa_q, opa_d;
    // Multiply: upper product half plus a guard bit so that subtracting the
    // most negative multiplicand cannot wrap. Divide: partial remainder.
    logic [WIDTH:0]   hi_q, hi_d;
    // Multiply: multiplier shifting out / product low half. Divide: dividend
    // magnitude shifting out / quotient shifting in.
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             booth_q, booth_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Booth iteration
    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   mul_sub;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   prod_top;
    logic             mul_ovf;

    // Restoring division iteration
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   div_hi_n;
    logic [WIDTH-1:0] div_lo_n;
    logic [WIDTH-1:0] quot_signed;
    logic             div_ovf;

    assign start     = (state_q == S_IDLE) && (ctrl_MULT || ctrl_DIV);
    assign last_iter = (cnt_q == LAST_ITER);

    assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    // Radix-2 Booth: the pair {multiplier LSB, previous LSB} selects
    // add / subtract / nothing, then the whole accumulator shifts right
    // arithmetically.
    always_comb begin
        mul_add = hi_q + {opa_q[WIDTH-1], opa_q};
        mul_sub = hi_q - {opa_q[WIDTH-1], opa_q};
        case ({lo_q[0], booth_q})
            2'b01:   mul_sum = mul_add;
            2'b10:   mul_sum = mul_sub;
            default: mul_sum = hi_q;
        endcase
        mul_hi_n = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    assign product  = {mul_hi_n[WIDTH-1:0], mul_lo_n};
    assign prod_top = product[2*WIDTH-1:WIDTH-1];
    // The product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
    assign mul_ovf  = ~((&prod_top) | ~(|prod_top));

    // Restoring shift-subtract on magnitudes. The remainder is always below
    // the divisor, so the shifted value fits WIDTH+1 bits and bit WIDTH of
    // the difference is a valid borrow.
    always_comb begin
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opa_q};
        if (!div_diff[WIDTH]) begin
            div_hi_n = div_diff;
            div_lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift;
            div_lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign quot_signed = neg_q ? (~div_lo_n + WIDTH'(1)) : div_lo_n;
    // Only MIN / -1 produces a positive quotient magnitude of 2^(WIDTH-1).
    assign div_ovf     = ~neg_q & div_lo_n[WIDTH-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        booth_d  = booth_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        res_d    = res_q;
        exc_d    = exc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = ~ctrl_MULT;
                    hi_d     = '0;
                    booth_d  = 1'b0;
                    neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dz_d     = (data_operandB == '0);
                    if (ctrl_MULT) begin
                        opa_d = data_operandA;
                        lo_d  = data_operandB;
                    end else begin
                        opa_d = b_mag;
                        lo_d  = a_mag;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    hi_d = div_hi_n;
                    lo_d = div_lo_n;
                end else begin
                    hi_d    = mul_hi_n;
                    lo_d    = mul_lo_n;
                    booth_d = lo_q[0];
                end
                if (last_iter) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        res_d = mul_lo_n;
                        exc_d = mul_ovf;
                    end else if (dz_q) begin
                        res_d = '0;
                        exc_d = 1'b1;
                    end else begin
                        res_d = quot_signed;
                        exc_d = div_ovf;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            booth_q  <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            booth_q  <= booth_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign stall          = start || (state_q == S_RUN);

endmodule

// File: tb/tb_execute_multdiv.sv
module tb_execute_multdiv;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        stall;

    execute_multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain 64-bit signed math.
    function automatic void ref_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        longint p;
        longint q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = q[31:0];
            e = (q > 64'sd2147483647);
        end
    endfunction

    // Transaction-level model: a busy unit counts down 32 edges after the
    // start edge, then shows ready for one cycle, then is free again.
    logic        m_active, m_ready, m_exc, p_exc;
    logic [31:0] m_res, p_res;
    int          m_left;

    always @(posedge clock) cyc++;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_ready  = 1'b0;
            m_res    = 32'd0;
            m_exc    = 1'b0;
            m_left   = 0;
        end else if (m_ready) begin
            m_ready = 1'b0;
        end else if (m_active) begin
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_ready  = 1'b1;
                m_res    = p_res;
                m_exc    = p_exc;
            end
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_active = 1'b1;
            m_left   = 32;
            ref_op(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clock) begin
        chk("ready",  {31'd0, data_resultRDY}, {31'd0, m_ready});
        chk("stall",  {31'd0, stall}, {31'd0, m_active | (~m_ready & (ctrl_MULT | ctrl_DIV))});
        chk("result", data_result, m_res);
        chk("exc",    {31'd0, data_exception}, {31'd0, m_exc});
    end

    int last_rdy;

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, output int lat, output int stall_cnt);
        @(posedge clock);
        #2;
        ctrl_MULT = m;
        ctrl_DIV  = d;
        data_operandA = a;
        data_operandB = b;
        #1;
        stall_cnt = stall ? 1 : 0;
        @(posedge clock);
        #1;
        if (stall) stall_cnt++;
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                last_rdy = cyc;
                break;
            end
            if (stall) stall_cnt++;
            if (k == inject_at) ctrl_DIV = 1'b1;
            if (k == inject_at + 1) ctrl_DIV = 1'b0;
        end
        ctrl_DIV = 1'b0;
        if (lat < 0) begin
            failures++;
            checks++;
            $display("FAIL ready_timeout: no ready within 40 edges (op a=%h b=%h)", a, b);
        end
    endtask

    task automatic directed(input string nm, input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic ee);
        int lat, sc;
        issue(m, d, a, b, 0, lat, sc);
        chk({nm, "_lat"}, lat, 32);
        chk({nm, "_res"}, data_result, er);
        chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(1, 20));
            5: return 32'(0) - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, sc, r1, r2, gap, sel;
        reset_n = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_result", data_result, 32'd0);
        chk("rst_ready",  {31'd0, data_resultRDY}, 32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        #1;
        reset_n = 1'b1;

        // 7 * -3 with latency and stall-length checks
        issue(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, lat, sc);
        chk("mul7x-3_lat",   lat, 32);
        chk("mul7x-3_stall", sc, 33);
        chk("mul7x-3_res",   data_result, 32'hFFFF_FFEB);
        chk("mul7x-3_exc",   {31'd0, data_exception}, 32'd0);

        directed("mul_ovf",   1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        directed("mul_min1",  1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
        directed("div-7/2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        directed("div_by0",   1'b0, 1'b1, 32'd100,       32'h0000_0000, 32'h0000_0000, 1'b1);
        directed("div_ovf",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        directed("both_mul",  1'b1, 1'b1, 32'd6,         32'd3,         32'd18,        1'b0);

        // divide request injected mid-run must be ignored
        issue(1'b1, 1'b0, 32'd9, 32'd11, 10, lat, sc);
        chk("inject_lat", lat, 32);
        chk("inject_res", data_result, 32'd99);
        r1 = last_rdy;
        // back-to-back start right after the ready cycle
        issue(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF6, 0, lat, sc);
        r2 = last_rdy;
        chk("b2b_interval", r2 - r1, 34);
        chk("b2b_res", data_result, 32'hFFFF_FF9C);

        // reset in the middle of a run
        @(posedge clock);
        #2;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd123;
        data_operandB = 32'd45;
        @(posedge clock);
        #2;
        ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exc",    {31'd0, data_exception}, 32'd0);
        chk("midrst_ready",  {31'd0, data_resultRDY}, 32'd0);
        chk("midrst_stall",  {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        directed("mul5x5", 1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0);

        // randomized operations, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clock);
            issue(sel == 0 || sel == 1 || sel == 4, sel >= 2, pick(), pick(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0, lat, sc);
            chk("rand_lat", lat, 32);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
